rbcp_bus_splitter: RTL and testbench
====================================

Name: rbcp_bus_splitter

Overview:
- Parametrised RBCP-side arbiter that fans one SiTCP RBCP port out to NUM_SLV generic byte-wide slave channels, one address window per channel.
- Each access is registered and issued as a single-cycle strobe to the selected slave. The splitter waits for that slave's ack and returns it, with its read data, to RBCP.
- Adds a per-access ack timeout, unmapped-address handling and a saturating error counter. A hung or absent slave therefore never stalls the RBCP host.
- Sits between SiTCP RBCP and the register table, system-monitor and Wishbone bridges in the top-level register block.

Parameters:
- NUM_SLV, 4: number of slave channels (1..16).
- WIN_BITS, 16: window size 2^WIN_BITS bytes. Slave i is selected when RBCP_ADDR[31:WIN_BITS] == i.
- TIMEOUT, 255: cycles to wait for a slave ack before a forced ack (1..65535).
- TO_DATA, 8'hEE: read data returned on timeout or unmapped access.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset
- RBCP_ACT  in  1  RBCP transaction active
- RBCP_ADDR  in  32  RBCP address
- RBCP_WE  in  1  write strobe, 1 cycle
- RBCP_WD  in  8  write data
- RBCP_RE  in  1  read strobe, 1 cycle
- RBCP_RD  out  8  read data, valid only while RBCP_ACK is high, else 0
- RBCP_ACK  out  1  acknowledge, 1 cycle
- S_ADDR  out  WIN_BITS  window offset of the latched access
- S_WD  out  8  latched write data
- S_WE  out  NUM_SLV  one-hot write strobe
- S_RE  out  NUM_SLV  one-hot read strobe
- S_RD  in  NUM_SLV*8  slave read data; slave i uses bits [8i+7:8i]
- S_ACK  in  NUM_SLV  slave acknowledge
- TO_CNT  out  16  saturating count of timeouts plus unmapped accesses
- BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset: RST synchronous, active-high; clock CLK. All outputs are 0 after reset. FSM goes to IDLE and the timeout counter clears.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, cycle T with RBCP_WE or RBCP_RE high:
  - Latch address, data and direction, and compute the slave index.
  - Mapped index (< NUM_SLV): go to ISSUE.
  - Unmapped index: go to RESP with forced data TO_DATA (reads; 0 for writes) and increment TO_CNT.
- ISSUE, cycle T+1: exactly one bit of S_WE or S_RE is high, at the selected index. S_ADDR and S_WD are stable from T+1 until return to IDLE. Next state is WAIT.
- WAIT:
  - S_ACK[sel] is sampled from T+1 onward. An ack in the ISSUE cycle is accepted.
  - On S_ACK[sel] at cycle K: capture S_RD[sel] for reads, go to RESP. RBCP_ACK is high at K+1 with RBCP_RD = captured data (0 for writes).
  - Acks on non-selected indices are ignored, as are simultaneous foreign acks.
  - Timeout counter starts at 0 in ISSUE and increments each WAIT cycle. When it reaches TIMEOUT with no ack: forced response (RBCP_RD = TO_DATA for reads, 0 for writes) and TO_CNT increment (saturates at 16'hFFFF).
  - RBCP_ACT low during ISSUE or WAIT: abort to IDLE, no RBCP_ACK, no TO_CNT change.
- RESP: RBCP_ACK high for 1 cycle, then IDLE.
- Late slave acks arriving after a timeout or abort are ignored.
- New RBCP strobes while BUSY are ignored.
- Minimum round trip: strobe at T, slave ack at T+1, RBCP_ACK at T+2.
- Unmapped access: RBCP_ACK at T+1 and no S_* strobe is issued.

Optional Feature:
- Macro RBCP_SPLIT_STATUS_EN.
- When defined, window index NUM_SLV is an internal status slave, answered in RESP at T+1 with no S_* strobe and no TO_CNT increment:
  - offset 0: read returns TO_CNT[15:8]; a write of any value clears TO_CNT.
  - offset 1: read returns TO_CNT[7:0].
  - offset 2: read returns the index of the last timed-out slave (8'hFF if none since reset).
  - other offsets: read returns 0.
- Not defined: index NUM_SLV is unmapped like every other index ≥ NUM_SLV.

Test Plan:
- Test setup for all cases: NUM_SLV=4, WIN_BITS=16, TIMEOUT=16.
- Write 0x0002_0034 data 0x5A at T; slave 2 acks at T+4 -> S_WE=4'b0100 only at T+1, S_ADDR=0x0034, S_WD=0x5A; RBCP_ACK at T+5, RBCP_RD=0x00; TO_CNT=0.
- Read 0x0001_0010 at T; S_ACK=4'b0011 at T+3 with S_RD slave1=0xC3, slave0=0x77 -> RBCP_ACK at T+4 with RBCP_RD=0xC3; slave-0 ack ignored.
- Read 0x0003_0000 with slave 3 never acking -> single RBCP_ACK at T+18, RBCP_RD=0xEE, TO_CNT 0->1. Slave-3 ack at T+20 -> no second RBCP_ACK.
- Read 0x0009_0000 -> RBCP_ACK at T+1, RBCP_RD=0xEE, no S_WE/S_RE activity, TO_CNT increments.
- RBCP_ACT low at T+5 during WAIT -> no RBCP_ACK, BUSY low at T+6. A following read to slave 0 completes normally. RST asserted at T+3 of a second access -> all outputs 0 at T+4.
- With RBCP_SPLIT_STATUS_EN, after 3 timeouts: read 0x0004_0001 -> 0x03 at T+1; write 0x0004_0000 -> TO_CNT=0 on the next cycle.

Source files
------------

// File: rtl/rbcp_bus_splitter.sv
// rbcp_bus_splitter: fans one SiTCP RBCP port out to NUM_SLV byte-wide slave
// channels. Each channel owns one 2^WIN_BITS-byte address window.
//
// Each RBCP access is latched and presented to the selected slave as a
// one-cycle strobe. The splitter then waits for that slave's ack and returns
// it, together with the slave's read data, to RBCP.
//
// A per-access timeout forces a response when the slave never acks. Accesses
// to unmapped windows are answered immediately. Both events bump a saturating
// error counter, TO_CNT.
//
// Optional feature, macro RBCP_SPLIT_STATUS_EN: window index NUM_SLV becomes
// an internal status slave. Offset 0 returns TO_CNT[15:8], and a write there
// clears TO_CNT. Offset 1 returns TO_CNT[7:0]. Offset 2 returns the index of
// the last timed-out slave.

module rbcp_bus_splitter #(
   parameter int          NUM_SLV  = 4,
   parameter int          WIN_BITS = 16,
   parameter int          TIMEOUT  = 255,
   parameter logic [7:0]  TO_DATA  = 8'hEE
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RBCP_ACT,
   input  logic [31:0]           RBCP_ADDR,
   input  logic                  RBCP_WE,
   input  logic [7:0]            RBCP_WD,
   input  logic                  RBCP_RE,
   output logic [7:0]            RBCP_RD,
   output logic                  RBCP_ACK,
   output logic [WIN_BITS-1:0]   S_ADDR,
   output logic [7:0]            S_WD,
   output logic [NUM_SLV-1:0]    S_WE,
   output logic [NUM_SLV-1:0]    S_RE,
   input  logic [NUM_SLV*8-1:0]  S_RD,
   input  logic [NUM_SLV-1:0]    S_ACK,
   output logic [15:0]           TO_CNT,
   output logic                  BUSY
);

   localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state;
   logic [SEL_W-1:0]  sel;        // latched slave index of the current access
   logic              is_wr;      // latched direction: 1 = write
   logic [15:0]       wait_cnt;   // cycles since the strobe was issued

   logic [31:0]       idx_full;
   logic              strobe;
   logic              mapped;
   logic [NUM_SLV-1:0] onehot;
   logic [SEL_W-1:0]  idx_sel;
   logic              sel_ack;
   logic [7:0]        sel_rd;

   assign idx_full = RBCP_ADDR >> WIN_BITS;
   assign strobe   = RBCP_WE | RBCP_RE;
   assign mapped   = idx_full < 32'(NUM_SLV);
   assign BUSY     = (state != IDLE);

   // Decode the live RBCP address into a one-hot strobe mask and a binary index.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      onehot  = '0;
      idx_sel = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (idx_full == 32'(i)) begin
            onehot[i] = 1'b1;
            idx_sel   = SEL_W'(i);
         end
      end
   end

   // Select ack and read data of the latched slave; foreign acks never reach the FSM.
   always_comb begin
      sel_ack = 1'b0;
      sel_rd  = 8'h00;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (sel == SEL_W'(i)) begin
            sel_ack = S_ACK[i];
            sel_rd  = S_RD[8*i +: 8];
         end
      end
   end

`ifdef RBCP_SPLIT_STATUS_EN
   logic       is_status;
   logic [7:0] status_rd;
   logic [7:0] last_to;     // index of the last slave that timed out, FF = none

   assign is_status = (idx_full == 32'(NUM_SLV));

   // Status slave read mux, addressed by the live window offset.
   always_comb begin
      status_rd = 8'h00;
      if (RBCP_ADDR[WIN_BITS-1:0] == WIN_BITS'(0))
         status_rd = TO_CNT[15:8];
      else if (RBCP_ADDR[WIN_BITS-1:0] == WIN_BITS'(1))
         status_rd = TO_CNT[7:0];
      else if (RBCP_ADDR[WIN_BITS-1:0] == WIN_BITS'(2))
         status_rd = last_to;
   end
`endif

   // Access FSM with registered strobes, ack, read data and error counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         sel      <= '0;
         is_wr    <= 1'b0;
         wait_cnt <= '0;
         RBCP_RD  <= 8'h00;
         RBCP_ACK <= 1'b0;
         S_ADDR   <= '0;
         S_WD     <= 8'h00;
         S_WE     <= '0;
         S_RE     <= '0;
         TO_CNT   <= 16'h0000;
`ifdef RBCP_SPLIT_STATUS_EN
         last_to  <= 8'hFF;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments only; these one-cycle pulses default low and are overridden below.
         RBCP_ACK <= 1'b0;
         RBCP_RD  <= 8'h00;
         S_WE     <= '0;
         S_RE     <= '0;
         case (state)
            IDLE: begin
               if (strobe) begin
                  S_ADDR   <= RBCP_ADDR[WIN_BITS-1:0];
                  S_WD     <= RBCP_WD;
                  is_wr    <= RBCP_WE;
                  sel      <= idx_sel;
                  wait_cnt <= '0;
`ifdef RBCP_SPLIT_STATUS_EN
                  if (is_status) begin
                     state    <= RESP;
                     RBCP_ACK <= 1'b1;
                     if (RBCP_WE) begin
                        if (RBCP_ADDR[WIN_BITS-1:0] == WIN_BITS'(0))
                           TO_CNT <= 16'h0000;
                     end else begin
                        RBCP_RD <= status_rd;
                     end
                  end else
`endif
                  if (mapped) begin
                     state <= ISSUE;
                     if (RBCP_WE)
                        S_WE <= onehot;
                     else
                        S_RE <= onehot;
                  end else begin
                     state    <= RESP;
                     RBCP_ACK <= 1'b1;
                     RBCP_RD  <= RBCP_WE ? 8'h00 : TO_DATA;
                     if (TO_CNT != 16'hFFFF)
                        TO_CNT <= TO_CNT + 16'd1;
                  end
               end
            end
            ISSUE, WAIT: begin
               if (!RBCP_ACT) begin
                  state <= IDLE;
               end else if (sel_ack) begin
                  state    <= RESP;
                  RBCP_ACK <= 1'b1;
                  RBCP_RD  <= is_wr ? 8'h00 : sel_rd;
               end else if (wait_cnt == 16'(TIMEOUT)) begin
                  state    <= RESP;
                  RBCP_ACK <= 1'b1;
                  RBCP_RD  <= is_wr ? 8'h00 : TO_DATA;
                  if (TO_CNT != 16'hFFFF)
                     TO_CNT <= TO_CNT + 16'd1;
`ifdef RBCP_SPLIT_STATUS_EN
                  last_to <= 8'(sel);
`endif
               end else begin
                  state    <= WAIT;
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rbcp_bus_splitter.sv
// Directed bench for rbcp_bus_splitter (NUM_SLV=4, WIN_BITS=16, TIMEOUT=16).
// A table of access records is replayed through a fixed 24-cycle window per
// access, followed by hand-written abort, reset and status-slave sequences.

module tb_rbcp_bus_splitter;

   localparam int NUM_SLV  = 4;
   localparam int WIN_BITS = 16;
   localparam int TIMEOUT  = 16;
   localparam int WINDOW   = 24;

   logic                  CLK = 1'b0;
   logic                  RST = 1'b1;
   logic                  RBCP_ACT = 1'b0;
   logic [31:0]           RBCP_ADDR = '0;
   logic                  RBCP_WE = 1'b0;
   logic [7:0]            RBCP_WD = '0;
   logic                  RBCP_RE = 1'b0;
   logic [7:0]            RBCP_RD;
   logic                  RBCP_ACK;
   logic [WIN_BITS-1:0]   S_ADDR;
   logic [7:0]            S_WD;
   logic [NUM_SLV-1:0]    S_WE;
   logic [NUM_SLV-1:0]    S_RE;
   logic [NUM_SLV*8-1:0]  S_RD = '0;
   logic [NUM_SLV-1:0]    S_ACK = '0;
   logic [15:0]           TO_CNT;
   logic                  BUSY;

   rbcp_bus_splitter #(
      .NUM_SLV  (NUM_SLV),
      .WIN_BITS (WIN_BITS),
      .TIMEOUT  (TIMEOUT),
      .TO_DATA  (8'hEE)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .RBCP_ACT  (RBCP_ACT),
      .RBCP_ADDR (RBCP_ADDR),
      .RBCP_WE   (RBCP_WE),
      .RBCP_WD   (RBCP_WD),
      .RBCP_RE   (RBCP_RE),
      .RBCP_RD   (RBCP_RD),
      .RBCP_ACK  (RBCP_ACK),
      .S_ADDR    (S_ADDR),
      .S_WD      (S_WD),
      .S_WE      (S_WE),
      .S_RE      (S_RE),
      .S_RD      (S_RD),
      .S_ACK     (S_ACK),
      .TO_CNT    (TO_CNT),
      .BUSY      (BUSY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [7:0]  wd;
      int          ack_at;     // cycle after T at which S_ACK is driven, 0 = never
      logic [3:0]  ack_mask;
      logic [31:0] s_rd;       // {slave3, slave2, slave1, slave0}
      int          exp_ack;    // cycle after T at which RBCP_ACK is expected
      logic [7:0]  exp_rd;
      logic [3:0]  exp_strb;   // one-hot strobe expected at T+1, 0 = none
      int          to_inc;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int exp_to = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Drive one access at cycle T and observe cycles T+1..T+WINDOW.
   task automatic run_vec(input string name, input vec_t v);
      int          ack_cnt = 0;
      int          ack_cyc = -1;
      logic [7:0]  ack_rd  = 8'h00;
      int          stray   = 0;
      int          rd_leak = 0;
      logic [3:0]  strb_we = 4'h0;
      logic [3:0]  strb_re = 4'h0;
      logic [15:0] addr_at1 = '0;
      logic [7:0]  wd_at1   = '0;
      @(posedge CLK); #1;
      RBCP_ACT  = 1'b1;
      RBCP_ADDR = v.addr;
      RBCP_WE   = v.wr;
      RBCP_RE   = !v.wr;
      RBCP_WD   = v.wd;
      S_RD      = v.s_rd;
      for (int c = 1; c <= WINDOW; c++) begin
         @(posedge CLK); #1;
         RBCP_WE = 1'b0;
         RBCP_RE = 1'b0;
         if (c == 1) begin
            strb_we  = S_WE;
            strb_re  = S_RE;
            addr_at1 = S_ADDR;
            wd_at1   = S_WD;
         end else if (S_WE != 0 || S_RE != 0) begin
            stray++;
         end
         if (RBCP_ACK) begin
            ack_cnt++;
            if (ack_cnt == 1) begin
               ack_cyc = c;
               ack_rd  = RBCP_RD;
            end
         end else if (RBCP_RD != 8'h00) begin
            rd_leak++;
         end
         S_ACK = (c == v.ack_at) ? v.ack_mask : 4'h0;
      end
      RBCP_ACT = 1'b0;
      S_ACK    = 4'h0;
      exp_to  += v.to_inc;
      check({name, " we@T+1"}, 64'(strb_we), v.wr ? 64'(v.exp_strb) : 64'd0);
      check({name, " re@T+1"}, 64'(strb_re), v.wr ? 64'd0 : 64'(v.exp_strb));
      if (v.exp_strb != 4'h0) begin
         check({name, " s_addr"}, 64'(addr_at1), 64'(v.addr[15:0]));
         if (v.wr)
            check({name, " s_wd"}, 64'(wd_at1), 64'(v.wd));
      end
      check({name, " stray strobes"}, 64'(stray), 64'd0);
      check({name, " ack cycle"}, 64'(ack_cyc), 64'(v.exp_ack));
      check({name, " ack count"}, 64'(ack_cnt), 64'd1);
      check({name, " rd"}, 64'(ack_rd), 64'(v.exp_rd));
      check({name, " rd outside ack"}, 64'(rd_leak), 64'd0);
      check({name, " to_cnt"}, 64'(TO_CNT), 64'(exp_to));
      check({name, " busy after"}, 64'(BUSY), 64'd0);
   endtask

   vec_t vecs[8];
   vec_t v_to3;
   vec_t v_rd0;

   initial begin
      int ack_cnt;

      vecs[0] = '{32'h0002_0034, 1'b1, 8'h5A, 4,  4'b0100, 32'h0000_0000,         5,  8'h00, 4'b0100, 0};
      vecs[1] = '{32'h0001_0010, 1'b0, 8'h00, 3,  4'b0011, 32'h0000_C377,         4,  8'hC3, 4'b0010, 0};
      vecs[2] = '{32'h0003_0000, 1'b0, 8'h00, 20, 4'b1000, 32'h1100_0000,         18, 8'hEE, 4'b1000, 1};
      vecs[3] = '{32'h0009_0000, 1'b0, 8'h00, 0,  4'b0000, 32'h0000_0000,         1,  8'hEE, 4'b0000, 1};
      vecs[4] = '{32'h0000_00FF, 1'b0, 8'h00, 1,  4'b0001, 32'h0000_003C,         2,  8'h3C, 4'b0001, 0};
      vecs[5] = '{32'h0001_0001, 1'b1, 8'h99, 0,  4'b0000, 32'h0000_0000,         18, 8'h00, 4'b0010, 1};
      vecs[6] = '{32'h0005_1234, 1'b1, 8'h11, 0,  4'b0000, 32'h0000_0000,         1,  8'h00, 4'b0000, 1};
      vecs[7] = '{32'h0003_ABCD, 1'b0, 8'h00, 17, 4'b1000, 32'hD400_0000,         18, 8'hD4, 4'b1000, 0};
      v_to3   = vecs[2];
      v_rd0   = '{32'h0000_0007, 1'b0, 8'h00, 2,  4'b0001, 32'h0000_005E,         3,  8'h5E, 4'b0001, 0};

      // Reset state.
      repeat (3) @(posedge CLK);
      #1;
      check("reset outputs", {RBCP_RD, RBCP_ACK, S_ADDR, S_WD, S_WE, S_RE, BUSY}, 64'd0);
      check("reset to_cnt", 64'(TO_CNT), 64'd0);
      RST = 1'b0;

      for (int i = 0; i < 8; i++)
         run_vec($sformatf("vec%0d", i), vecs[i]);

      // Abort: RBCP_ACT drops at T+5 while waiting on slave 1.
      @(posedge CLK); #1;
      RBCP_ACT  = 1'b1;
      RBCP_ADDR = 32'h0001_0000;
      RBCP_RE   = 1'b1;
      ack_cnt   = 0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge CLK); #1;
         RBCP_RE = 1'b0;
         if (RBCP_ACK) ack_cnt++;
         if (c == 5) begin
            check("abort busy@T+5", 64'(BUSY), 64'd1);
            RBCP_ACT = 1'b0;
         end
         if (c == 6) check("abort busy@T+6", 64'(BUSY), 64'd0);
         if (c == 8) S_ACK = 4'b0010;  // late ack after abort
         else        S_ACK = 4'b0000;
      end
      check("abort no ack", 64'(ack_cnt), 64'd0);
      check("abort to_cnt", 64'(TO_CNT), 64'(exp_to));
      run_vec("after abort", v_rd0);

      // Reset in the middle of an access at T+3.
      @(posedge CLK); #1;
      RBCP_ACT  = 1'b1;
      RBCP_ADDR = 32'h0002_00A5;
      RBCP_RE   = 1'b1;
      @(posedge CLK); #1;
      RBCP_RE = 1'b0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      check("mid reset outputs", {RBCP_RD, RBCP_ACK, S_ADDR, S_WD, S_WE, S_RE, BUSY}, 64'd0);
      check("mid reset to_cnt", 64'(TO_CNT), 64'd0);
      RST      = 1'b0;
      RBCP_ACT = 1'b0;
      exp_to   = 0;

`ifdef RBCP_SPLIT_STATUS_EN
      begin
         vec_t vs;
         for (int i = 0; i < 3; i++)
            run_vec($sformatf("st timeout%0d", i), v_to3);
         vs = '{32'h0004_0001, 1'b0, 8'h00, 0, 4'b0000, 32'h0, 1, 8'h03, 4'b0000, 0};
         run_vec("status off1", vs);
         vs.addr = 32'h0004_0002;
         run_vec("status off2", vs);
         vs.addr = 32'h0004_0000; vs.exp_rd = 8'h00;
         run_vec("status off0", vs);
         vs.addr = 32'h0004_0007;
         run_vec("status off7", vs);
         @(posedge CLK); #1;
         RBCP_ACT  = 1'b1;
         RBCP_ADDR = 32'h0004_0000;
         RBCP_WE   = 1'b1;
         RBCP_WD   = 8'h5C;
         @(posedge CLK); #1;
         RBCP_WE = 1'b0;
         check("status clr ack", 64'(RBCP_ACK), 64'd1);
         check("status clr to_cnt", 64'(TO_CNT), 64'd0);
         RBCP_ACT = 1'b0;
         exp_to   = 0;
      end
`endif

      run_vec("final write", vecs[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
